// File: rtl/mips_pkg.sv
// Shared types and default widths for the data-memory arbiter and its response router.
package mips_pkg;

    localparam int DEFAULT_AW = 8;
    localparam int DEFAULT_DW = 32;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } arb_owner_e;

    typedef enum logic {
        ARB_IDLE     = 1'b0,
        ARB_DBG_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_rsp_route.sv
// One-deep read response tracker: remembers who issued the granted read and steers
// the memory's read data and a one-cycle valid pulse back to that port only.
module dmem_rsp_route
    import mips_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          rd_issue,
    input  arb_owner_e    rd_owner,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata
);

    logic          rsp_valid;
    arb_owner_e    rsp_owner;
    logic [DW-1:0] core_rdata_q;
    logic [DW-1:0] dbg_rdata_q;

    // Read data arrives during the response cycle, so it is passed straight through
    // and captured at the end of that cycle so the port keeps it afterwards.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_valid    <= 1'b0;
            rsp_owner    <= OWN_CORE;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            rsp_valid <= rd_issue;
            rsp_owner <= rd_owner;
            if (core_rvalid) core_rdata_q <= mem_rdata;
            if (dbg_rvalid)  dbg_rdata_q  <= mem_rdata;
        end
    end

    assign core_rvalid = rsp_valid && (rsp_owner == OWN_CORE);
    assign dbg_rvalid  = rsp_valid && (rsp_owner == OWN_DBG);
    assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
    assign dbg_rdata   = dbg_rvalid  ? mem_rdata : dbg_rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the core load/store port and the debug port.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise core has fixed priority
// with a debug starvation counter.
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int AW           = DEFAULT_AW,
    parameter int DW           = DEFAULT_DW,
    parameter int STARVE_LIMIT = 15
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    logic          locked;
    logic          contend;
    logic          dbg_wins;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    arb_owner_e    rd_owner;

`ifdef DMEM_ARB_RR_EN
    arb_owner_e favour_q, favour_d;
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_q, starve_d;
`endif

    // Grants are gated by reset so every output sits at zero while reset is held.
    // Dropping dbg_lock or dbg_req releases the lock in that same cycle.
    always_comb begin
        state_d  = state_q;
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        locked   = (state_q == ARB_DBG_LOCK) && dbg_req && dbg_lock;
        contend  = core_req && dbg_req && !locked;
`ifdef DMEM_ARB_RR_EN
        favour_d = favour_q;
        dbg_wins = (favour_q == OWN_DBG);
`else
        starve_d = starve_q;
        dbg_wins = (starve_q == CW'(STARVE_LIMIT));
`endif
        if (RST_N) begin
            if (locked) begin
                dbg_gnt = 1'b1;
            end else if (contend) begin
                dbg_gnt  = dbg_wins;
                core_gnt = !dbg_wins;
            end else begin
                core_gnt = core_req;
                dbg_gnt  = dbg_req;
            end
        end
        state_d = (dbg_gnt && dbg_lock) ? ARB_DBG_LOCK : ARB_IDLE;
`ifdef DMEM_ARB_RR_EN
        if (contend && RST_N) favour_d = core_gnt ? OWN_DBG : OWN_CORE;
`else
        if (!dbg_req || dbg_gnt) begin
            starve_d = '0;
        end else if (starve_q != CW'(STARVE_LIMIT)) begin
            starve_d = starve_q + CW'(1);
        end
`endif
    end

    assign core_stall = RST_N && core_req && !core_gnt;
    assign mem_en     = core_gnt || dbg_gnt;
    assign mem_we     = dbg_gnt ? dbg_we : (core_gnt ? core_we : 1'b0);
    assign mem_addr   = dbg_gnt ? dbg_addr : (core_gnt ? core_addr : addr_q);
    assign mem_wdata  = dbg_gnt ? dbg_wdata : (core_gnt ? core_wdata : wdata_q);
    assign rd_owner   = dbg_gnt ? OWN_DBG : OWN_CORE;

    // Address and write data are re-registered every cycle so idle cycles replay them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ARB_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
            favour_q <= OWN_CORE;
`else
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
`ifdef DMEM_ARB_RR_EN
            favour_q <= favour_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

    dmem_rsp_route #(.DW(DW)) u_rsp_route (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .rd_issue    (mem_en && !mem_we),
        .rd_owner    (rd_owner),
        .mem_rdata   (mem_rdata),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: a simple dmem model plus a cycle-level reference
// of the arbitration rules, the expected memory image and the read responses.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SL = 3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_gnt, core_stall, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    // Reference state
    bit            m_lock, m_fav_dbg, m_pend, m_pend_dbg;
    int            m_cnt;
    logic [DW-1:0] m_pend_data, m_core_rd, m_dbg_rd, m_wdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] shadow [0:255];

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_core_gnt"}, core_gnt, 0);
        check_output({tag, "_dbg_gnt"}, dbg_gnt, 0);
        check_output({tag, "_stall"}, core_stall, 0);
        check_output({tag, "_mem_en"}, mem_en, 0);
        check_output({tag, "_mem_we"}, mem_we, 0);
        check_output({tag, "_mem_addr"}, mem_addr, 0);
        check_output({tag, "_mem_wdata"}, mem_wdata, 0);
        check_output({tag, "_core_rvalid"}, core_rvalid, 0);
        check_output({tag, "_dbg_rvalid"}, dbg_rvalid, 0);
        check_output({tag, "_core_rdata"}, core_rdata, 0);
        check_output({tag, "_dbg_rdata"}, dbg_rdata, 0);
    endtask

    task automatic model_reset();
        m_lock = 0; m_fav_dbg = 0; m_pend = 0; m_pend_dbg = 0; m_cnt = 0;
        m_pend_data = '0; m_core_rd = '0; m_dbg_rd = '0; m_addr = '0; m_wdata = '0;
    endtask

    // Called at a falling edge with inputs already applied; checks the whole cycle,
    // advances the reference at the rising edge and returns at the next falling edge.
    task automatic apply_stimulus(output bit gc, output bit gd);
        bit lk, both, dw, ee, ewe, crv, drv;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd, crd, drd;
        #1;
        lk   = m_lock && dbg_req && dbg_lock;
        both = core_req && dbg_req;
`ifdef DMEM_ARB_RR_EN
        dw = m_fav_dbg;
`else
        dw = (m_cnt == SL);
`endif
        if (lk)        begin gd = 1; gc = 0; end
        else if (both) begin gd = dw; gc = !dw; end
        else           begin gc = core_req; gd = dbg_req; end
        ee  = gc || gd;
        ewe = gd ? dbg_we : (gc ? core_we : 1'b0);
        ea  = gd ? dbg_addr : (gc ? core_addr : m_addr);
        ewd = gd ? dbg_wdata : (gc ? core_wdata : m_wdata);
        crv = m_pend && !m_pend_dbg;
        drv = m_pend && m_pend_dbg;
        crd = crv ? m_pend_data : m_core_rd;
        drd = drv ? m_pend_data : m_dbg_rd;
        check_output("core_gnt", core_gnt, gc);
        check_output("dbg_gnt", dbg_gnt, gd);
        check_output("core_stall", core_stall, core_req && !gc);
        check_output("mem_en", mem_en, ee);
        check_output("mem_we", mem_we, ewe);
        check_output("mem_addr", mem_addr, ea);
        check_output("mem_wdata", mem_wdata, ewd);
        check_output("core_rvalid", core_rvalid, crv);
        check_output("dbg_rvalid", dbg_rvalid, drv);
        check_output("core_rdata", core_rdata, crd);
        check_output("dbg_rdata", dbg_rdata, drd);
        @(posedge CLK);
        m_core_rd   = crd;
        m_dbg_rd    = drd;
        m_pend      = ee && !ewe;
        m_pend_dbg  = gd;
        m_pend_data = shadow[ea];
        if (ee && ewe) shadow[ea] = ewd;
        m_addr  = ea;
        m_wdata = ewd;
        if (!dbg_req || gd) m_cnt = 0;
        else if (m_cnt < SL) m_cnt++;
        if (both && !lk) m_fav_dbg = gc;
        m_lock = gd && dbg_lock;
        @(negedge CLK);
    endtask

    initial begin
        bit gc, gd;
        bit [7:0] gd_seq;
        int stalls;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        model_reset();

        // Reset with both ports requesting: everything stays at zero until release.
        core_req = 1; core_we = 1; core_addr = 8'h00; core_wdata = 32'h1111_0000;
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h01; dbg_wdata = 32'h2222_0001;
        repeat (2) @(negedge CLK);
        check_reset_outputs("rst");
        RST_N = 1;
        apply_stimulus(gc, gd);
        check_output("rst_first_core", gc, 1);

        // Preload the low words through the debug port.
        core_req = 0;
        for (int a = 0; a < 16; a++) begin
            dbg_req = 1; dbg_we = 1; dbg_addr = AW'(a); dbg_wdata = $urandom;
            apply_stimulus(gc, gd);
        end

        // Single debug write then read-back.
        dbg_we = 1; dbg_addr = 8'h04; dbg_wdata = 32'hDEADBEEF;
        apply_stimulus(gc, gd);
        dbg_we = 0;
        apply_stimulus(gc, gd);
        dbg_req = 0;
        #1;
        check_output("t2_dbg_rvalid", dbg_rvalid, 1);
        check_output("t2_dbg_rdata", dbg_rdata, 32'hDEADBEEF);
        check_output("t2_core_rvalid", core_rvalid, 0);
        apply_stimulus(gc, gd);

        // Locked debug burst to 0x10..0x13 while the core waits.
        stalls = 0;
        core_we = 0; core_addr = 8'h10;
        for (int i = 0; i < 4; i++) begin
            core_req = (i != 0);
            dbg_req = 1; dbg_lock = 1; dbg_we = 1;
            dbg_addr = AW'(8'h10 + i); dbg_wdata = 32'hA5A5_0000 + i;
            #1;
            if (core_stall) stalls++;
            apply_stimulus(gc, gd);
        end
        check_output("t5_stalls", stalls, 3);
        dbg_req = 0; dbg_lock = 0;
        for (int i = 0; i < 4; i++) begin
            core_addr = AW'(8'h10 + i);
            apply_stimulus(gc, gd);
            check_output("t5_core_gnt", gc, 1);
        end
        core_req = 0;
        apply_stimulus(gc, gd);
        check_output("t5_word3", core_rdata, 32'hA5A5_0003);

        // Reset pulled while a core read is outstanding.
        core_req = 1; core_we = 0; core_addr = 8'h05;
        #1;
        check_output("t6_core_gnt", core_gnt, 1);
        #1 RST_N = 0;
        #1 check_reset_outputs("t6");
        model_reset();
        @(negedge CLK);
        core_req = 0;
        RST_N = 1;
        apply_stimulus(gc, gd);
        check_output("t6_no_rvalid", core_rvalid, 0);

        // Continuous contention from fresh reset state.
        core_req = 1; core_we = 0; core_addr = 8'h02;
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h03; dbg_lock = 0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(gc, gd);
            gd_seq[i] = gd;
        end
`ifdef DMEM_ARB_RR_EN
        check_output("contend_seq", gd_seq, 8'b1010_1010);
`else
        check_output("contend_seq", gd_seq, 8'b1000_1000);
`endif

        // Random traffic; requests are held until granted.
        gc = 1; gd = 1;
        for (int n = 0; n < 400; n++) begin
            if (!core_req || gc) begin
                core_req = ($urandom % 4) != 0; core_we = $urandom % 2;
                core_addr = AW'($urandom % 16); core_wdata = $urandom;
            end
            if (!dbg_req || gd) begin
                dbg_req = ($urandom % 3) != 0; dbg_we = $urandom % 2;
                dbg_addr = AW'($urandom % 16); dbg_wdata = $urandom;
            end
            dbg_lock = ($urandom % 3) == 0;
            apply_stimulus(gc, gd);
        end
        core_req = 0; dbg_req = 0; dbg_lock = 0;
        repeat (2) apply_stimulus(gc, gd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
